// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master controller.
// Holds the FSM state encoding and the transmit fill helpers.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        STORE,
        FINISH
    } spi_state_t;

    localparam int         SPI_BITS   = 8;
    localparam logic [7:0] FILL_ONES  = 8'hFF;
    localparam logic [7:0] FILL_ZEROS = 8'h00;

    // all_ones takes priority over all_zeros
    function automatic logic [7:0] pick_tx(
        input logic       ones,
        input logic       zeros,
        input logic [7:0] data
    );
        if (ones)
            return FILL_ONES;
        else if (zeros)
            return FILL_ZEROS;
        else
            return data;
    endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// One SPI mode-0 byte transfer, MSB first.
// SCLK divider plus tx/rx shift registers; mosi holds its last bit when idle.
module spi_byte_shifter
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic [7:0] rx_byte,
    output logic       byte_done
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [2:0] BIT_LAST = 3'(SPI_BITS - 1);

    logic          active;
    logic [CW-1:0] div_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    tx_sr;
    logic [7:0]    rx_sr;
    logic          tick;

    assign tick      = active && (div_cnt == DIV_LAST);
    assign byte_done = tick && sclk && (bit_cnt == BIT_LAST);
    assign mosi      = tx_sr[7];
    assign rx_byte   = rx_sr;

    // Half-period divider; sample on rising SCLK, shift on falling SCLK
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active  <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            sclk    <= 1'b0;
            tx_sr   <= '0;
            rx_sr   <= '0;
        end else if (start) begin
            active  <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
            sclk    <= 1'b0;
            tx_sr   <= tx_byte;
        end else if (active) begin
            if (tick) begin
                div_cnt <= '0;
                if (!sclk) begin
                    sclk  <= 1'b1;
                    rx_sr <= {rx_sr[6:0], miso};
                end else begin
                    sclk <= 1'b0;
                    if (bit_cnt == BIT_LAST) begin
                        active <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        tx_sr   <= {tx_sr[6:0], 1'b0};
                    end
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI burst master: reads tx bytes from the data register file,
// shifts them out and writes the received bytes back in place.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int N       = 5,
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        send,
    input  logic [N:0]  n_tx_end,
    input  logic        all_ones,
    input  logic        all_zeros,
    output logic [N:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic        hold_ctrl,
    output logic        wr_en,
    output logic [N:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso,
    output logic        cs_n,
    output logic        busy,
    output logic        done,
    output logic [N:0]  n_rx
);

    localparam logic [N:0] IDX_MAX = (N + 1)'(N);

    spi_state_t state;
    spi_state_t state_next;

    logic [N:0] end_idx;
    logic [N:0] index;
    logic       start_byte;
    logic [7:0] tx_byte;
    logic [7:0] rx_byte;
    logic       byte_done;
    logic       unused_rd_hi;

    assign tx_byte      = pick_tx(all_ones, all_zeros, rd_data[7:0]);
    assign unused_rd_hi = ^rd_data[31:8];

    spi_byte_shifter #(
        .CLK_DIV(CLK_DIV)
    ) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .start    (start_byte),
        .tx_byte  (tx_byte),
        .miso     (miso),
        .sclk     (sclk),
        .mosi     (mosi),
        .rx_byte  (rx_byte),
        .byte_done(byte_done)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state and per-state strobes
    always_comb begin
        state_next = state;
        start_byte = 1'b0;
        unique case (state)
            IDLE: begin
                if (send)
                    state_next = LOAD;
            end
            LOAD: begin
                start_byte = 1'b1;
                state_next = SHIFT;
            end
            SHIFT: begin
                if (byte_done)
                    state_next = STORE;
            end
            STORE: begin
                if (index == end_idx)
                    state_next = FINISH;
                else
                    state_next = LOAD;
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Burst bookkeeping and register file interface
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= 1'b0;
            hold_ctrl <= 1'b0;
            cs_n      <= 1'b1;
            done      <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            rd_addr   <= '0;
            n_rx      <= '0;
            index     <= '0;
            end_idx   <= '0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (send) begin
                        end_idx   <= (n_tx_end > IDX_MAX) ? IDX_MAX : n_tx_end;
                        index     <= '0;
                        rd_addr   <= '0;
                        n_rx      <= '0;
                        busy      <= 1'b1;
                        hold_ctrl <= 1'b1;
                        cs_n      <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (byte_done) begin
                        wr_en   <= 1'b1;
                        wr_addr <= index;
                        wr_data <= rx_byte;
                        n_rx    <= n_rx + 1'b1;
                    end
                end
                STORE: begin
                    if (index == end_idx) begin
                        done      <= 1'b1;
                        cs_n      <= 1'b1;
                        busy      <= 1'b0;
                        hold_ctrl <= 1'b0;
                    end else begin
                        index   <= index + 1'b1;
                        rd_addr <= index + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
